// File: rtl/lsu_req_queue.sv
// In-order LSU request buffer. Each entry carries a fwd_ok bit that is cleared by younger non-LSU writers to its rd.
// Optional zero-latency pass-through when empty: define LSU_REQ_QUEUE_BYPASS_EN.

package lsu_req_queue_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        rf_we;
    logic [1:0]  data_type;
    logic        sign_ext;
    logic        is_cap;
    logic        cache_ok;
  } lsu_req_info_t;

  typedef struct packed {
    logic [1:0] valid;
    logic [4:0] rd0;
    logic [4:0] rd1;
  } waw_act_t;

  localparam lsu_req_info_t NULL_LSU_REQ_INFO = '0;

endpackage

module lsu_req_queue
  import lsu_req_queue_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  localparam int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            us_valid_i,
  input  lsu_req_info_t   lsu_req_dec_i,
  output logic            lspl_rdy_o,
  output logic            lsu_req_o,
  output lsu_req_info_t   lsu_req_info_o,
  input  logic            lsu_req_done_i,
  input  waw_act_t        waw_act_i,
  output logic            fwd_ok_o,
  output logic [CntW-1:0] occupancy_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;
  lsu_req_info_t   mem_q [Depth];
  logic [Depth-1:0] fwd_ok_q;
  logic [Depth-1:0] entry_vld;

  logic empty;
  logic full;
  logic enq;
  logic deq;
  logic enq_wr;
  logic deq_rd;
  logic byp_act;
  logic byp_consume;
  logic new_fwd_ok;

  function automatic logic waw_hit(input waw_act_t w, input logic [4:0] rd);
    return (w.valid[0] && (w.rd0 == rd)) || (w.valid[1] && (w.rd1 == rd));
  endfunction

  assign empty       = (count_q == '0);
  assign full        = (count_q == CntW'(Depth));
  assign lspl_rdy_o  = ~full;
  assign occupancy_o = count_q;
  assign enq         = us_valid_i & ~full;

`ifdef LSU_REQ_QUEUE_BYPASS_EN
  assign byp_act = empty & us_valid_i;
`else
  assign byp_act = 1'b0;
`endif

  assign lsu_req_o   = ~empty | byp_act;
  assign deq         = lsu_req_o & lsu_req_done_i;
  // A bypassed request retired in its arrival cycle never touches storage.
  assign byp_consume = byp_act & lsu_req_done_i;
  assign enq_wr      = enq & ~byp_consume;
  assign deq_rd      = deq & ~empty;
  assign new_fwd_ok  = lsu_req_dec_i.rf_we & (lsu_req_dec_i.rd != 5'd0);

  always_comb begin
    lsu_req_info_o = NULL_LSU_REQ_INFO;
    fwd_ok_o       = 1'b0;
    if (!empty) begin
      lsu_req_info_o = mem_q[rd_ptr_q];
      fwd_ok_o       = fwd_ok_q[rd_ptr_q];
    end else if (byp_act) begin
      lsu_req_info_o = lsu_req_dec_i;
      fwd_ok_o       = new_fwd_ok & ~waw_hit(waw_act_i, lsu_req_dec_i.rd);
    end
  end

  // Entry i is live when its distance from the head is below the count.
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      entry_vld[i] = CntW'(PtrW'(PtrW'(i) - rd_ptr_q)) < count_q;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({enq_wr, deq_rd})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fwd_ok_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fwd_ok_q <= '0;
    end else begin
      if (enq_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (deq_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      for (int i = 0; i < Depth; i++) begin
        if (entry_vld[i] && waw_hit(waw_act_i, mem_q[i].rd)) fwd_ok_q[i] <= 1'b0;
      end
      // The incoming entry is younger than any same-cycle writer, so its bit wins.
      if (enq_wr) fwd_ok_q[wr_ptr_q] <= new_fwd_ok;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_wr && !flush_i) mem_q[wr_ptr_q] <= lsu_req_dec_i;
  end

endmodule

// File: tb/tb_lsu_req_queue.sv
// Directed self-checking bench for lsu_req_queue (Depth=4).
module tb_lsu_req_queue;
  import lsu_req_queue_pkg::*;

  localparam int Depth = 4;
  localparam int CntW  = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            us_valid_i;
  lsu_req_info_t   lsu_req_dec_i;
  logic            lspl_rdy_o;
  logic            lsu_req_o;
  lsu_req_info_t   lsu_req_info_o;
  logic            lsu_req_done_i;
  waw_act_t        waw_act_i;
  logic            fwd_ok_o;
  logic [CntW-1:0] occupancy_o;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_req_queue #(.Depth(Depth)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .us_valid_i     (us_valid_i),
    .lsu_req_dec_i  (lsu_req_dec_i),
    .lspl_rdy_o     (lspl_rdy_o),
    .lsu_req_o      (lsu_req_o),
    .lsu_req_info_o (lsu_req_info_o),
    .lsu_req_done_i (lsu_req_done_i),
    .waw_act_i      (waw_act_i),
    .fwd_ok_o       (fwd_ok_o),
    .occupancy_o    (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic lsu_req_info_t mk(input logic [31:0] addr, input logic [4:0] rd, input logic we);
    lsu_req_info_t r;
    r           = '0;
    r.addr      = addr;
    r.wdata     = addr ^ 32'hA5A5_0000;
    r.rd        = rd;
    r.rf_we     = we;
    r.data_type = 2'd2;
    r.cache_ok  = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] addr, input logic [4:0] rd, input logic we);
    us_valid_i    = 1'b1;
    lsu_req_dec_i = mk(addr, rd, we);
    tick();
    us_valid_i    = 1'b0;
  endtask

  task automatic pop();
    lsu_req_done_i = 1'b1;
    tick();
    lsu_req_done_i = 1'b0;
  endtask

  initial begin
    rst_ni         = 1'b0;
    flush_i        = 1'b0;
    us_valid_i     = 1'b0;
    lsu_req_dec_i  = '0;
    lsu_req_done_i = 1'b0;
    waw_act_i      = '0;
    #12;
    chk("rst_rdy",   lspl_rdy_o, 1);
    chk("rst_req",   lsu_req_o, 0);
    chk("rst_info",  lsu_req_info_o, 96'(NULL_LSU_REQ_INFO));
    chk("rst_fwd",   fwd_ok_o, 0);
    chk("rst_occ",   occupancy_o, 0);
    #2 rst_ni = 1'b1;
    tick();

    // first enqueue: visible one cycle later
    push(32'h1000, 5'd5, 1'b1);
    chk("e1_req",  lsu_req_o, 1);
    chk("e1_addr", lsu_req_info_o.addr, 32'h1000);
    chk("e1_info", lsu_req_info_o, 96'(mk(32'h1000, 5'd5, 1'b1)));
    chk("e1_fwd",  fwd_ok_o, 1);
    chk("e1_occ",  occupancy_o, 1);
    pop();
    chk("e1_occ_after", occupancy_o, 0);

    // fill to Depth, blocked 5th with same-cycle dequeue
    for (int k = 0; k < 4; k++) push(32'(4 * k), 5'(k + 1), 1'b1);
    chk("full_rdy", lspl_rdy_o, 0);
    chk("full_occ", occupancy_o, 4);
    us_valid_i     = 1'b1;
    lsu_req_dec_i  = mk(32'h10, 5'd9, 1'b1);
    lsu_req_done_i = 1'b1;
    tick();
    us_valid_i     = 1'b0;
    lsu_req_done_i = 1'b0;
    chk("full_blk_occ",  occupancy_o, 3);
    chk("full_blk_rdy",  lspl_rdy_o, 1);
    for (int k = 1; k < 4; k++) begin
      chk("drain_addr", lsu_req_info_o.addr, 32'(4 * k));
      pop();
    end
    chk("drain_req", lsu_req_o, 0);
    chk("drain_occ", occupancy_o, 0);

    // WAW clearing and same-cycle enqueue exemption
    push(32'h100, 5'd7, 1'b1);
    chk("waw_fwd0", fwd_ok_o, 1);
    us_valid_i      = 1'b1;
    lsu_req_dec_i   = mk(32'h104, 5'd7, 1'b1);
    waw_act_i.valid = 2'b10;
    waw_act_i.rd1   = 5'd7;
    tick();
    us_valid_i = 1'b0;
    waw_act_i  = '0;
    chk("waw_fwd_clr", fwd_ok_o, 0);
    chk("waw_req",     lsu_req_o, 1);
    chk("waw_addr",    lsu_req_info_o.addr, 32'h100);
    chk("waw_occ",     occupancy_o, 2);
    pop();
    chk("waw_new_addr", lsu_req_info_o.addr, 32'h104);
    chk("waw_new_fwd",  fwd_ok_o, 1);
    waw_act_i.valid = 2'b01;
    waw_act_i.rd0   = 5'd3;
    tick();
    chk("waw_miss_fwd", fwd_ok_o, 1);
    waw_act_i.rd0 = 5'd7;
    tick();
    waw_act_i = '0;
    chk("waw_rd0_fwd", fwd_ok_o, 0);
    pop();
    push(32'h110, 5'd0, 1'b1);
    chk("fwd_rd0", fwd_ok_o, 0);
    pop();
    push(32'h114, 5'd3, 1'b0);
    chk("fwd_nowe", fwd_ok_o, 0);
    pop();

    // pointer wrap with two resident entries
    push(32'h200, 5'd1, 1'b1);
    push(32'h204, 5'd1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      us_valid_i     = 1'b1;
      lsu_req_dec_i  = mk(32'h208 + 32'(4 * k), 5'd1, 1'b1);
      lsu_req_done_i = 1'b1;
      #1;
      chk("wrap_head", lsu_req_info_o.addr, 32'h200 + 32'(4 * k));
      tick();
      chk("wrap_occ", occupancy_o, 2);
    end
    us_valid_i     = 1'b0;
    lsu_req_done_i = 1'b0;
    chk("wrap_tail0", lsu_req_info_o.addr, 32'h228);
    pop();
    chk("wrap_tail1", lsu_req_info_o.addr, 32'h22C);
    pop();
    chk("wrap_empty", occupancy_o, 0);

    // flush beats same-cycle enqueue and dequeue
    for (int k = 0; k < 3; k++) push(32'h300 + 32'(4 * k), 5'd2, 1'b1);
    chk("pre_flush_occ", occupancy_o, 3);
    flush_i        = 1'b1;
    us_valid_i     = 1'b1;
    lsu_req_dec_i  = mk(32'h30C, 5'd2, 1'b1);
    lsu_req_done_i = 1'b1;
    tick();
    flush_i        = 1'b0;
    us_valid_i     = 1'b0;
    lsu_req_done_i = 1'b0;
    chk("flush_occ",  occupancy_o, 0);
    chk("flush_req",  lsu_req_o, 0);
    chk("flush_info", lsu_req_info_o, 96'(NULL_LSU_REQ_INFO));
    chk("flush_fwd",  fwd_ok_o, 0);
    chk("flush_rdy",  lspl_rdy_o, 1);
    push(32'h310, 5'd4, 1'b1);
    chk("post_flush_addr", lsu_req_info_o.addr, 32'h310);
    chk("post_flush_occ",  occupancy_o, 1);
    pop();

    // empty queue, valid and done together
    us_valid_i     = 1'b1;
    lsu_req_dec_i  = mk(32'h2000, 5'd6, 1'b1);
    lsu_req_done_i = 1'b1;
    #1;
`ifdef LSU_REQ_QUEUE_BYPASS_EN
    chk("byp_req",  lsu_req_o, 1);
    chk("byp_addr", lsu_req_info_o.addr, 32'h2000);
    chk("byp_fwd",  fwd_ok_o, 1);
`else
    chk("nobyp_req", lsu_req_o, 0);
`endif
    tick();
    us_valid_i     = 1'b0;
    lsu_req_done_i = 1'b0;
`ifdef LSU_REQ_QUEUE_BYPASS_EN
    chk("byp_occ", occupancy_o, 0);
`else
    chk("nobyp_occ",  occupancy_o, 1);
    chk("nobyp_addr", lsu_req_info_o.addr, 32'h2000);
    pop();
`endif

    // asynchronous reset mid-operation
    push(32'h400, 5'd8, 1'b1);
    push(32'h404, 5'd8, 1'b1);
    chk("pre_rst_occ", occupancy_o, 2);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_occ",  occupancy_o, 0);
    chk("arst_req",  lsu_req_o, 0);
    chk("arst_rdy",  lspl_rdy_o, 1);
    chk("arst_fwd",  fwd_ok_o, 0);
    chk("arst_info", lsu_req_info_o, 96'(NULL_LSU_REQ_INFO));
    #2 rst_ni = 1'b1;
    tick();
    chk("post_rst_occ", occupancy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_req_queue.md
Name: lsu_req_queue

Overview:
In-order request buffer between the load/store dispatch point and the LSU/dcache snoop interface. Accepts decoded LSU requests from the upstream pipeline and presents the oldest one as lsu_req_o/lsu_req_info_o. The LSU retires it with lsu_req_done_i. Each entry carries a fwd_ok bit, cleared when a younger non-LSU writer to the same rd is dispatched; the dcache uses this bit to suppress stale load forwarding.

Parameters:
Depth, 4, number of entries; power of 2, range 2..16
CntW, $clog2(Depth)+1, occupancy counter width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; discards all entries
us_valid_i  in  1  upstream request valid
lsu_req_dec_i  in  lsu_req_info_t  decoded request (addr, wdata, rd, rf_we, data_type, sign_ext, is_cap, cache_ok)
lspl_rdy_o  out  1  queue can accept a request
lsu_req_o  out  1  head request valid
lsu_req_info_o  out  lsu_req_info_t  head request payload
lsu_req_done_i  in  1  LSU accepted head this cycle
waw_act_i  in  waw_act_t  valid[1:0], rd0, rd1 of newly dispatched non-LSU register writers
fwd_ok_o  out  1  head entry still owns its rd (forwarding permitted)
occupancy_o  out  CntW  number of valid entries

Behaviour:
- Reset values: lspl_rdy_o=1, lsu_req_o=0, lsu_req_info_o=NULL_LSU_REQ_INFO, fwd_ok_o=0, occupancy_o=0. Pointers and count are 0, and all entry fwd_ok bits are 0.
- Storage: circular array of Depth entries. wr_ptr and rd_ptr are log2(Depth) bits and wrap naturally from Depth-1 to 0. count is CntW bits.
- Enqueue: enq = us_valid_i & lspl_rdy_o. The payload is written at wr_ptr, and wr_ptr increments.
- Dequeue: deq = lsu_req_o & lsu_req_done_i. rd_ptr increments.
- lspl_rdy_o = (count != Depth).
  - Depends only on registered count, with no combinational path from lsu_req_done_i.
  - When full, enqueue is blocked even if a dequeue occurs in the same cycle.
- lsu_req_o = (count != 0).
  - lsu_req_info_o shows the entry at rd_ptr when non-empty and NULL_LSU_REQ_INFO when empty.
  - lsu_req_info_o is stable while lsu_req_o=1 and deq=0.
- Latency: an entry enqueued in cycle N is visible at the head no earlier than cycle N+1.
- Simultaneous enq and deq: count is unchanged and both pointers advance.
- fwd_ok per entry:
  - On enqueue, set to lsu_req_dec_i.rf_we & (rd != 0).
  - Each cycle, cleared for every valid entry where (waw_act_i.valid[0] & rd0==entry.rd) | (waw_act_i.valid[1] & rd1==entry.rd).
  - An entry enqueued in the same cycle as a matching waw_act_i is NOT cleared; the writer is treated as older.
  - fwd_ok_o = lsu_req_o & head.fwd_ok, combinational from the head entry's registered bit.
  - A waw_act_i match on the head in cycle N makes fwd_ok_o low in cycle N+1.
- Flush:
  - flush_i=1 sets count, wr_ptr, rd_ptr and all fwd_ok bits to 0 next cycle.
  - Flush takes priority over a same-cycle enq and deq. The enqueued request is dropped, and lsu_req_done_i has no effect on state.
  - Payload RAM is not cleared.
- Reset mid-operation: asynchronous return to reset values. Any in-flight head is abandoned.
- occupancy_o = count.

Optional Feature:
LSU_REQ_QUEUE_BYPASS_EN:
- When defined and count==0 and us_valid_i=1:
  - lsu_req_o=1 and lsu_req_info_o=lsu_req_dec_i in the same cycle (zero-latency pass-through).
  - fwd_ok_o = rf_we & (rd!=0) & ~(same-cycle waw_act_i match).
  - If lsu_req_done_i=1 in that cycle, the request is consumed and not written: count stays 0, and wr_ptr and rd_ptr are unchanged.
  - Otherwise it is stored normally.
- When undefined: the minimum latency is 1 cycle as specified above.

Test Plan:
- Reset, then enqueue addr 0x1000 rd=5 rf_we=1 with lsu_req_done_i=0 -> next cycle lsu_req_o=1, lsu_req_info_o.addr=0x1000, fwd_ok_o=1, occupancy_o=1.
- Depth=4: enqueue 4 requests with no dequeue -> lspl_rdy_o=0 and occupancy_o=4. A 5th us_valid_i with lsu_req_done_i=1 in the same cycle is not accepted. Heads are then drained in order addr 0x0,0x4,0x8,0xC.
- Queue holds rd=7 at head; waw_act_i.valid=2'b10, rd1=7 -> fwd_ok_o=0 next cycle and the entry is still present. A same-cycle enqueue of rd=7 keeps fwd_ok=1 on the new entry.
- Wrap: 10 back-to-back enq and deq pairs with 2 entries resident -> order preserved across pointer wrap, occupancy_o stays at 2.
- 3 entries resident; flush_i=1 together with us_valid_i=1 and lsu_req_done_i=1 -> next cycle occupancy_o=0, lsu_req_o=0, lsu_req_info_o=NULL_LSU_REQ_INFO.
- With LSU_REQ_QUEUE_BYPASS_EN, empty queue, us_valid_i=1 and lsu_req_done_i=1 with addr 0x2000 -> lsu_req_info_o.addr=0x2000 in the same cycle and occupancy_o=0 next cycle. Without the macro, lsu_req_o=0 in that cycle.
